flag_update_ctrl: RTL and testbench

Sequencing controller for the 5-bit processor status register. It merges masked ALU flag updates and explicit software flag writes into a single load stream (`sr_ld`/`sr_flags_in`) that drives the status register's `ld`/`flags_in`. It also provides an interrupt save/restore stack for the flags. It keeps a shadow copy equal to the status register contents, so back-to-back masked updates never merge against stale flags.

---
 rtl/flag_update_ctrl.sv | 129 ++++++++++++
 tb/tb_flag_update_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/flag_update_ctrl.sv
// Status-register load sequencer: merges masked ALU flag updates and software
// writes into one registered load stream, with an interrupt save/restore stack.
module flag_update_ctrl #(
  parameter int unsigned FLAG_W      = 5,
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned AW         = $clog2(STACK_DEPTH),
  localparam int unsigned DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [FLAG_W-1:0] alu_mask,
  input  logic              sw_wr,
  input  logic [FLAG_W-1:0] sw_flags,
  input  logic              irq_save,
  input  logic              irq_restore,
  input  logic              err_clr,
  output logic              ready,
  output logic              sr_ld,
  output logic [FLAG_W-1:0] sr_flags_in,
  output logic [FLAG_W-1:0] flags,
  output logic [DW-1:0]     depth,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  typedef enum logic {IDLE, RESTORE} state_t;

  state_t            state_q, state_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [FLAG_W-1:0] sr_flags_q, sr_flags_d;
  logic              sr_ld_q, sr_ld_d;
  logic [FLAG_W-1:0] rbuf_q, rbuf_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              err_q, err_d;
  logic [FLAG_W-1:0] stack_q [STACK_DEPTH];

  logic              err_set;
  logic              push;
  logic              restore_acc;
  logic [DW-1:0]     top_idx;

  assign stack_empty = (depth_q == '0);
  assign stack_full  = (depth_q == DW'(STACK_DEPTH));
  assign restore_acc = (state_q == IDLE) && irq_restore && !stack_empty;
  assign ready       = (state_q == IDLE) && !(irq_restore && !stack_empty);
  assign top_idx     = depth_q - DW'(1);

  assign sr_ld       = sr_ld_q;
  assign sr_flags_in = sr_flags_q;
  assign flags       = flags_q;
  assign depth       = depth_q;
  assign stack_err   = err_q;

  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    sr_flags_d = sr_flags_q;
    sr_ld_d    = 1'b0;
    rbuf_d     = rbuf_q;
    depth_d    = depth_q;
    err_set    = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (restore_acc) begin
          rbuf_d  = stack_q[top_idx[AW-1:0]];
          depth_d = top_idx;
          state_d = RESTORE;
          err_set = irq_save;
        end else begin
          err_set = irq_restore;
          if (sw_wr) begin
            flags_d    = sw_flags;
            sr_flags_d = sw_flags;
            sr_ld_d    = 1'b1;
          end else if (alu_valid) begin
            flags_d    = (flags_q & ~alu_mask) | (alu_flags & alu_mask);
            sr_flags_d = flags_d;
            sr_ld_d    = 1'b1;
          end
          // A save pushes the pre-update flags; the write port uses flags_q.
          if (irq_save) begin
            if (stack_full) begin
              err_set = 1'b1;
            end else begin
              push    = 1'b1;
              depth_d = depth_q + DW'(1);
            end
          end
        end
      end
      RESTORE: begin
        flags_d    = rbuf_q;
        sr_flags_d = rbuf_q;
        sr_ld_d    = 1'b1;
        state_d    = IDLE;
        err_set    = irq_save;
      end
      default: state_d = IDLE;
    endcase
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      flags_q    <= '0;
      sr_flags_q <= '0;
      sr_ld_q    <= 1'b0;
      rbuf_q     <= '0;
      depth_q    <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      sr_flags_q <= sr_flags_d;
      sr_ld_q    <= sr_ld_d;
      rbuf_q     <= rbuf_d;
      depth_q    <= depth_d;
      err_q      <= err_d;
      if (push) stack_q[depth_q[AW-1:0]] <= flags_q;
    end
  end

endmodule

// File: tb/tb_flag_update_ctrl.sv
// Self-checking bench for flag_update_ctrl: directed plan steps plus random
// traffic compared against a queue-based behavioural model.
module tb_flag_update_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alu_valid = 1'b0, sw_wr = 1'b0, irq_save = 1'b0;
  logic       irq_restore = 1'b0, err_clr = 1'b0;
  logic [4:0] alu_flags = '0, alu_mask = '0, sw_flags = '0;
  logic       ready, sr_ld, stack_full, stack_empty, stack_err;
  logic [4:0] sr_flags_in, flags;
  logic [2:0] depth;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [4:0] m_flags, m_sr_in, m_rbuf;
  logic       m_sr_ld, m_err, m_in_restore;
  logic [4:0] m_stack[$];

  flag_update_ctrl #(.FLAG_W(5), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_flags(alu_flags), .alu_mask(alu_mask),
    .sw_wr(sw_wr), .sw_flags(sw_flags),
    .irq_save(irq_save), .irq_restore(irq_restore), .err_clr(err_clr),
    .ready(ready), .sr_ld(sr_ld), .sr_flags_in(sr_flags_in), .flags(flags),
    .depth(depth), .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_flags = '0; m_sr_in = '0; m_rbuf = '0;
    m_sr_ld = 1'b0; m_err = 1'b0; m_in_restore = 1'b0;
    m_stack.delete();
  endtask

  task automatic chk_comb(input string tag);
    chk({tag, "_ready"}, {7'd0, ready},
        {7'd0, !m_in_restore && !(irq_restore && m_stack.size() != 0)});
    chk({tag, "_depth"}, {5'd0, depth}, 8'(m_stack.size()));
    chk({tag, "_full"},  {7'd0, stack_full},  {7'd0, m_stack.size() == 4});
    chk({tag, "_empty"}, {7'd0, stack_empty}, {7'd0, m_stack.size() == 0});
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_sr_ld"}, {7'd0, sr_ld}, {7'd0, m_sr_ld});
    chk({tag, "_sr_in"}, {3'd0, sr_flags_in}, {3'd0, m_sr_in});
    chk({tag, "_flags"}, {3'd0, flags}, {3'd0, m_flags});
    chk({tag, "_err"},   {7'd0, stack_err}, {7'd0, m_err});
  endtask

  // One clock: apply inputs, check combinational outputs, clock, update model, check.
  task automatic step(input string tag, input logic av, input logic [4:0] af,
                      input logic [4:0] am, input logic sw, input logic [4:0] sf,
                      input logic sv, input logic rs, input logic ec);
    logic set;
    alu_valid = av; alu_flags = af; alu_mask = am;
    sw_wr = sw; sw_flags = sf; irq_save = sv; irq_restore = rs; err_clr = ec;
    #1;
    chk_comb(tag);
    set = 1'b0;
    m_sr_ld = 1'b0;
    if (m_in_restore) begin
      m_flags = m_rbuf; m_sr_in = m_rbuf; m_sr_ld = 1'b1;
      m_in_restore = 1'b0;
      set = sv;
    end else if (rs && m_stack.size() != 0) begin
      m_rbuf = m_stack.pop_back();
      m_in_restore = 1'b1;
      set = sv;
    end else begin
      logic [4:0] old;
      old = m_flags;
      if (rs) set = 1'b1;
      if (sw) begin
        m_flags = sf; m_sr_in = sf; m_sr_ld = 1'b1;
      end else if (av) begin
        m_flags = (old & ~am) | (af & am); m_sr_in = m_flags; m_sr_ld = 1'b1;
      end
      if (sv) begin
        if (m_stack.size() == 4) set = 1'b1;
        else m_stack.push_back(old);
      end
    end
    m_err = set ? 1'b1 : (ec ? 1'b0 : m_err);
    @(posedge clk);
    #1;
    chk_regs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    m_reset();
    #12;
    chk("reset_ready", {7'd0, ready}, 8'd1);
    chk("reset_empty", {7'd0, stack_empty}, 8'd1);
    chk_regs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset-release ALU update
    step("first_alu", 1'b1, 5'b11111, 5'b00011, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("first_alu_val", {3'd0, sr_flags_in}, 8'h03);

    // Merge chain
    step("chain_sw", 1'b0, '0, '0, 1'b1, 5'b10100, 1'b0, 1'b0, 1'b0);
    step("chain_alu", 1'b1, 5'b00001, 5'b00011, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("chain_val", {3'd0, sr_flags_in}, 8'h15);

    // Priority
    step("prio", 1'b1, 5'b00000, 5'b11111, 1'b1, 5'b01010, 1'b0, 1'b0, 1'b0);
    chk("prio_val", {3'd0, flags}, 8'h0a);
    idle("prio_idle");

    // Save with concurrent write, then restore
    step("save_sw", 1'b0, '0, '0, 1'b1, 5'b00001, 1'b1, 1'b0, 1'b0);
    chk("save_depth", {5'd0, depth}, 8'd1);
    step("restore", 1'b1, 5'b11111, 5'b11111, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step("restore_bubble", 1'b1, 5'b11111, 5'b11111, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("restore_val", {3'd0, sr_flags_in}, 8'h0a);
    idle("restore_done");

    // Overflow then underflow
    for (int i = 0; i < 5; i++)
      step("ovf_save", 1'b1, 5'(i), 5'b11111, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("ovf_err", {7'd0, stack_err}, 8'd1);
    chk("ovf_full", {7'd0, stack_full}, 8'd1);
    step("err_clr", 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step("unf_rest", 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      if (i < 4) idle("unf_idle");
    end
    chk("unf_err", {7'd0, stack_err}, 8'd1);
    chk("unf_depth", {5'd0, depth}, 8'd0);
    step("err_clr_win", 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Async reset mid-RESTORE
    step("ar_save", 1'b0, '0, '0, 1'b1, 5'b10001, 1'b1, 1'b0, 1'b0);
    step("ar_save2", 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("ar_rest", 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    alu_valid = 1'b0; irq_restore = 1'b0; irq_save = 1'b0; sw_wr = 1'b0; err_clr = 1'b0;
    #2 rst = 1'b0;
    #1;
    m_reset();
    chk_regs("ar_now");
    chk_comb("ar_now");
    @(posedge clk); #3 rst = 1'b1;
    idle("ar_after");
    idle("ar_after2");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom % 3) == 0, 5'($urandom), 5'($urandom),
           ($urandom % 5) == 0, 5'($urandom), ($urandom % 4) == 0,
           ($urandom % 6) == 0, ($urandom % 8) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
